gearbox_stim_gen: RTL and testbench

//  Parametrised multi-frame stimulus source for gearbox benches (32->24 and wider variants).

---
 rtl/gearbox_stim_if.sv | 23 ++
 rtl/gearbox_stim_gen.sv | 171 +++++++++++++++++
 tb/tb_gearbox_stim_gen.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_stim_if.sv
// Beat stream between the stimulus source and the gearbox under test.
interface gearbox_stim_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              data_ready;
    logic              data_en;
    logic              data_in_last;
    logic [DATA_W-1:0] data_in_rgb;

    modport master (
        input  data_ready,
        output data_en,
        output data_in_last,
        output data_in_rgb
    );

    modport slave (
        output data_ready,
        input  data_en,
        input  data_in_last,
        input  data_in_rgb
    );
endinterface

// File: rtl/gearbox_stim_gen.sv
// Multi-frame beat source: per-lane incrementing pattern, frame-end marker,
// selectable gap gating and ready backpressure.
module gearbox_stim_gen #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned LANE_W     = 8,
    parameter int unsigned START_DLY  = 1000,
    parameter int unsigned FRAME_LEN  = 9012,
    parameter int unsigned NUM_FRAMES = 1,
    parameter int unsigned IFG        = 16,
    parameter int unsigned GAP_MODE   = 0,
    parameter int unsigned GAP_PERIOD = 4,
    parameter logic [15:0] SEED       = 16'hACE1
) (
    input  logic                  clk_200m,
    input  logic                  reset,
    gearbox_stim_if.master        bus,
    output logic [15:0]           frame_cnt,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned DataW = LANES * LANE_W;

    typedef enum logic [1:0] {StWait, StSend, StIfg, StDone} state_e;

    state_e             state_q;
    logic [31:0]        wait_cnt_q;
    logic [31:0]        beat_cnt_q;
    logic [31:0]        ifg_cnt_q;
    logic [31:0]        phase_q;
    logic [15:0]        lfsr_q;
    logic [DataW-1:0]   data_q;
    logic               en_q;
    logic               last_q;
    logic [15:0]        frame_cnt_q;
    logic               busy_q;
    logic               done_q;

    logic               xfer;
    logic               frame_end;
    logic               final_frame;
    logic               gate_open;
    logic [31:0]        beat_nxt;
    logic               last_nxt;
    logic [31:0]        phase_nxt;
    logic [15:0]        lfsr_nxt;

    function automatic logic [DataW-1:0] init_pattern();
        logic [DataW-1:0] p;
        p = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            p[i*LANE_W +: LANE_W] = LANE_W'(16 * (i + 1));
        end
        return p;
    endfunction

    // Each lane wraps on its own, so increment lane by lane rather than the whole word.
    function automatic logic [DataW-1:0] next_pattern(input logic [DataW-1:0] d);
        logic [DataW-1:0] p;
        p = d;
        for (int i = 0; i < int'(LANES); i++) begin
            p[i*LANE_W +: LANE_W] = d[i*LANE_W +: LANE_W] + LANE_W'(1);
        end
        return p;
    endfunction

    always_comb begin
        xfer        = en_q & bus.data_ready;
        frame_end   = xfer && (beat_cnt_q == FRAME_LEN - 1);
        final_frame = (NUM_FRAMES != 0) && (({16'd0, frame_cnt_q} + 32'd1) == NUM_FRAMES);
        beat_nxt    = beat_cnt_q;
        if (xfer) begin
            beat_nxt = frame_end ? 32'd0 : beat_cnt_q + 32'd1;
        end
        last_nxt  = (beat_nxt == FRAME_LEN - 1);
        phase_nxt = (phase_q == GAP_PERIOD - 1) ? 32'd0 : phase_q + 32'd1;
        // Galois form of x^16+x^14+x^13+x^11+1, shifting right.
        lfsr_nxt  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        if (GAP_MODE == 1) begin
            gate_open = (phase_q < GAP_PERIOD / 2);
        end else if (GAP_MODE == 2) begin
            gate_open = lfsr_q[0];
        end else begin
            gate_open = 1'b1;
        end
    end

    always_ff @(posedge clk_200m) begin
        if (reset) begin
            state_q     <= StWait;
            wait_cnt_q  <= '0;
            beat_cnt_q  <= '0;
            ifg_cnt_q   <= '0;
            phase_q     <= '0;
            lfsr_q      <= SEED;
            data_q      <= init_pattern();
            en_q        <= 1'b0;
            last_q      <= 1'b0;
            frame_cnt_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            phase_q <= phase_nxt;
            lfsr_q  <= lfsr_nxt;
            unique case (state_q)
                StWait: begin
                    if (wait_cnt_q == START_DLY - 1) begin
                        state_q <= StSend;
                        busy_q  <= 1'b1;
                        en_q    <= gate_open;
                        last_q  <= last_nxt;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 32'd1;
                    end
                end
                StSend: begin
                    if (xfer) begin
                        data_q     <= next_pattern(data_q);
                        beat_cnt_q <= beat_nxt;
                        if (frame_end && frame_cnt_q != 16'hFFFF) begin
                            frame_cnt_q <= frame_cnt_q + 16'd1;
                        end
                        if (frame_end && final_frame) begin
                            state_q <= StDone;
                            en_q    <= 1'b0;
                            last_q  <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (frame_end && IFG != 0) begin
                            state_q   <= StIfg;
                            ifg_cnt_q <= '0;
                            en_q      <= 1'b0;
                            last_q    <= 1'b0;
                        end else begin
                            en_q   <= gate_open;
                            last_q <= last_nxt;
                        end
                    end else if (!en_q) begin
                        // A pending beat is never withdrawn; gating only applies when idle.
                        en_q   <= gate_open;
                        last_q <= last_nxt;
                    end
                end
                StIfg: begin
                    if (ifg_cnt_q == IFG - 1) begin
                        state_q <= StSend;
                        en_q    <= gate_open;
                        last_q  <= last_nxt;
                    end else begin
                        ifg_cnt_q <= ifg_cnt_q + 32'd1;
                    end
                end
                StDone: begin
                    en_q   <= 1'b0;
                    last_q <= 1'b0;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: state_q <= StDone;
            endcase
        end
    end

    assign bus.data_en      = en_q;
    assign bus.data_in_last = last_q;
    assign bus.data_in_rgb  = data_q;
    assign frame_cnt        = frame_cnt_q;
    assign busy             = busy_q;
    assign done             = done_q;

endmodule

// File: tb/tb_gearbox_stim_gen.sv
// Directed bench: default single frame with backpressure, periodic gaps,
// three short frames with IFG, and mid-frame reset.
module tb_gearbox_stim_gen;

    logic clk_200m = 1'b0;
    logic reset_a, reset_b, reset_c;
    logic [15:0] frame_cnt_a, frame_cnt_b, frame_cnt_c;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    always #5 clk_200m = ~clk_200m;

    gearbox_stim_if #(.DATA_W(32)) bus_a ();
    gearbox_stim_if #(.DATA_W(32)) bus_b ();
    gearbox_stim_if #(.DATA_W(32)) bus_c ();

    gearbox_stim_gen u_dut_a (
        .clk_200m  (clk_200m),
        .reset     (reset_a),
        .bus       (bus_a),
        .frame_cnt (frame_cnt_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    gearbox_stim_gen #(.START_DLY(9), .GAP_MODE(1), .GAP_PERIOD(4)) u_dut_b (
        .clk_200m  (clk_200m),
        .reset     (reset_b),
        .bus       (bus_b),
        .frame_cnt (frame_cnt_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    gearbox_stim_gen #(.START_DLY(3), .FRAME_LEN(5), .NUM_FRAMES(3), .IFG(2)) u_dut_c (
        .clk_200m  (clk_200m),
        .reset     (reset_c),
        .bus       (bus_c),
        .frame_cnt (frame_cnt_c),
        .busy      (busy_c),
        .done      (done_c)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Beat n, lane i = 16*(i+1) + n mod 256.
    function automatic logic [31:0] pat(input int n);
        logic [31:0] p;
        for (int i = 0; i < 4; i++) p[i*8 +: 8] = 8'((16 * (i + 1) + n) % 256);
        return p;
    endfunction

    initial begin
        int c, n, steps, k;
        logic [31:0] held;
        reset_a = 1'b1;
        reset_b = 1'b1;
        reset_c = 1'b1;
        bus_a.data_ready = 1'b1;
        bus_b.data_ready = 1'b1;
        bus_c.data_ready = 1'b1;
        repeat (3) @(posedge clk_200m);
        @(negedge clk_200m);

        check_eq("rst_en", bus_a.data_en, 0);
        check_eq("rst_last", bus_a.data_in_last, 0);
        check_eq("rst_data", bus_a.data_in_rgb, 32'h40302010);
        check_eq("rst_frame_cnt", frame_cnt_a, 0);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_done", done_a, 0);

        // Default configuration, one 9012-beat frame, 5-cycle stall at beat 100.
        reset_a = 1'b0;
        c = 0;
        while (!bus_a.data_en && c < 2000) begin
            @(negedge clk_200m);
            c++;
            if (c == 999) check_eq("a_busy_during_wait", busy_a, 0);
        end
        check_eq("a_first_offer_cycle", c, 1000);
        check_eq("a_busy", busy_a, 1);
        n = 0;
        steps = 0;
        while (n < 9012 && steps < 12000) begin
            if (bus_a.data_en) begin
                check_eq("a_data", bus_a.data_in_rgb, pat(n));
                check_eq("a_last", bus_a.data_in_last, 32'(n == 9011));
                if (n == 0) check_eq("a_beat0", bus_a.data_in_rgb, 32'h40302010);
                if (n == 1) check_eq("a_beat1", bus_a.data_in_rgb, 32'h41312111);
                if (n == 240) check_eq("a_beat240_lane0", bus_a.data_in_rgb[7:0], 0);
                if (n == 256) check_eq("a_beat256", bus_a.data_in_rgb, 32'h40302010);
                if (n == 9011) check_eq("a_last_beat", bus_a.data_in_rgb, 32'h73635343);
                if (n == 100) begin
                    held = bus_a.data_in_rgb;
                    bus_a.data_ready = 1'b0;
                    repeat (5) begin
                        @(negedge clk_200m);
                        check_eq("a_stall_en", bus_a.data_en, 1);
                        check_eq("a_stall_data", bus_a.data_in_rgb, held);
                    end
                    bus_a.data_ready = 1'b1;
                end
                n++;
            end
            @(negedge clk_200m);
            steps++;
        end
        check_eq("a_beats", n, 9012);
        check_eq("a_no_gaps", steps, 9012);
        check_eq("a_end_en", bus_a.data_en, 0);
        check_eq("a_done", done_a, 1);
        check_eq("a_frame_cnt", frame_cnt_a, 1);
        check_eq("a_end_busy", busy_a, 0);

        // Periodic gaps: offers in the first half of each 4-cycle period.
        reset_b = 1'b0;
        c = 0;
        while (!bus_b.data_en && c < 100) begin
            @(negedge clk_200m);
            c++;
        end
        check_eq("b_first_offer_cycle", c, 9);
        n = 0;
        k = 0;
        while (n < 9012 && k < 20000) begin
            check_eq("b_gap_en", bus_b.data_en, 32'((k % 4) < 2));
            if (bus_b.data_en) begin
                check_eq("b_data", bus_b.data_in_rgb, pat(n));
                check_eq("b_last", bus_b.data_in_last, 32'(n == 9011));
                n++;
            end
            @(negedge clk_200m);
            k++;
        end
        check_eq("b_beats", n, 9012);
        check_eq("b_done", done_b, 1);
        check_eq("b_frame_cnt", frame_cnt_b, 1);

        // Three 5-beat frames with two idle cycles between them.
        reset_c = 1'b0;
        n = 0;
        for (int cc = 1; cc <= 24; cc++) begin
            @(negedge clk_200m);
            check_eq("c_en", bus_c.data_en,
                     32'((cc >= 3 && cc <= 7) || (cc >= 10 && cc <= 14) || (cc >= 17 && cc <= 21)));
            check_eq("c_frame_cnt", frame_cnt_c,
                     (cc >= 22) ? 3 : (cc >= 15) ? 2 : (cc >= 8) ? 1 : 0);
            check_eq("c_done", done_c, 32'(cc >= 22));
            if (bus_c.data_en) begin
                check_eq("c_data", bus_c.data_in_rgb, pat(n));
                check_eq("c_last", bus_c.data_in_last, 32'((n % 5) == 4));
                n++;
            end
            if (cc == 17) check_eq("c_frame2_beat0", bus_c.data_in_rgb, 32'h4A3A2A1A);
        end
        check_eq("c_beats", n, 15);
        check_eq("c_end_busy", busy_c, 0);

        // Reset with a beat pending in the middle of the second frame.
        reset_c = 1'b1;
        @(negedge clk_200m);
        reset_c = 1'b0;
        c = 0;
        while (!(bus_c.data_en && frame_cnt_c == 16'd1) && c < 50) begin
            @(negedge clk_200m);
            c++;
        end
        check_eq("c_f1_offer_cycle", c, 10);
        check_eq("c_f1_beat0", bus_c.data_in_rgb, 32'h45352515);
        bus_c.data_ready = 1'b0;
        @(negedge clk_200m);
        check_eq("c_pending_en", bus_c.data_en, 1);
        check_eq("c_pending_data", bus_c.data_in_rgb, 32'h45352515);
        reset_c = 1'b1;
        @(negedge clk_200m);
        check_eq("c_rst_en", bus_c.data_en, 0);
        check_eq("c_rst_data", bus_c.data_in_rgb, 32'h40302010);
        check_eq("c_rst_frame_cnt", frame_cnt_c, 0);
        check_eq("c_rst_busy", busy_c, 0);
        check_eq("c_rst_done", done_c, 0);
        reset_c = 1'b0;
        bus_c.data_ready = 1'b1;
        c = 0;
        while (!bus_c.data_en && c < 50) begin
            @(negedge clk_200m);
            c++;
        end
        check_eq("c_restart_cycle", c, 3);
        check_eq("c_restart_data", bus_c.data_in_rgb, 32'h40302010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
